// File: rtl/mnist_frame_feeder.sv
// mnist_frame_feeder
//   Host-side driver for the network core's pixel-stream input. The host
//   fills a one-frame buffer. A start request streams the frame into the core
//   as a valid-qualified byte stream. The block then waits for the core's
//   32-bit result, captures it and pulses result_done_o. If no result arrives
//   in time, it pulses timeout_err_o instead.
//
// Ports
//   clk                  single clock
//   rst_n                asynchronous active-low reset
//   wr_en_i              frame-buffer write strobe (dropped while busy or out of range)
//   wr_addr_i[ADDR_W]    pixel index to write
//   wr_data_i[8]         pixel value
//   start_i              one-cycle inference request (accepted only in IDLE)
//   busy_o               high from accepted start until return to IDLE
//   pixel_out_o[8]       pixel to core, holds last value between valid cycles
//   pixel_valid_o        pixel_out_o qualifier
//   core_result_i[32]    core result bus
//   core_result_valid_i  core result qualifier (only honoured in WAIT)
//   result_o[32]         last captured core result
//   result_done_o        one-cycle pulse: result_o updated
//   timeout_err_o        one-cycle pulse: WAIT expired with no result
module mnist_frame_feeder #(
    parameter int N_PIXELS       = 784,
    parameter int ADDR_W         = 10,
    parameter int GAP            = 0,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [7:0]        wr_data_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic [7:0]        pixel_out_o,
    output logic              pixel_valid_o,
    input  logic [31:0]       core_result_i,
    input  logic              core_result_valid_i,
    output logic [31:0]       result_o,
    output logic              result_done_o,
    output logic              timeout_err_o
);

    localparam int GAP_W  = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [ADDR_W:0]   NPIX     = (ADDR_W + 1)'(N_PIXELS);
    localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W + 1)'(N_PIXELS - 1);
    localparam logic [ADDR_W:0]   IDX_ONE  = (ADDR_W + 1)'(1);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP);
    localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
    localparam logic [TCNT_W-1:0] TMAX     = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TCNT_ONE = TCNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic [ADDR_W:0]     idx_q, idx_d;       // next address to read; N_PIXELS = all issued
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                rd_vld_q, rd_vld_d; // RAM read issued last cycle
    logic                rd_last_q, rd_last_d;
    logic                pix_vld_q, pix_vld_d;
    logic                pix_last_q, pix_last_d;
    logic [7:0]          pix_q, pix_d;
    logic [31:0]         result_q, result_d;
    logic                done_q, done_d;
    logic                tout_q, tout_d;

    logic [7:0]          frame_mem [N_PIXELS];
    logic [7:0]          rd_data_q;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic                wr_accept;

    assign wr_accept = wr_en_i && !busy_q && ({1'b0, wr_addr_i} < NPIX);
    assign rd_addr   = idx_q[ADDR_W-1:0];

    // Buffer contents survive reset, so the RAM has no reset branch.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            frame_mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en) begin
            rd_data_q <= frame_mem[rd_addr];
        end
    end

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        tcnt_d     = tcnt_q;
        result_d   = result_q;
        done_d     = 1'b0;
        tout_d     = 1'b0;
        rd_en      = 1'b0;
        rd_vld_d   = 1'b0;
        rd_last_d  = 1'b0;
        // Output stage: one register after the RAM read register. This gives
        // the two-cycle start-to-first-pixel latency. The pixel value is held
        // whenever no read result is arriving.
        pix_d      = pix_q;
        pix_vld_d  = rd_vld_q;
        pix_last_d = rd_vld_q & rd_last_q;
        if (rd_vld_q) begin
            pix_d = rd_data_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_STREAM;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    gap_d   = '0;
                end
            end
            S_STREAM: begin
                if (idx_q < NPIX) begin
                    if (gap_q == '0) begin
                        rd_en     = 1'b1;
                        rd_vld_d  = 1'b1;
                        rd_last_d = (idx_q == LAST_IDX);
                        idx_d     = idx_q + IDX_ONE;
                        gap_d     = GAP_LOAD;
                    end else begin
                        gap_d = gap_q - GAP_ONE;
                    end
                end
                // Leave only once the final pixel has actually been presented.
                if (pix_vld_q && pix_last_q) begin
                    state_d = S_WAIT;
                    tcnt_d  = '0;
                end
            end
            S_WAIT: begin
                // A result on the expiry cycle still wins over the timeout.
                if (core_result_valid_i) begin
                    result_d = core_result_i;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end else if (tcnt_q == TMAX) begin
                    tout_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TCNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            idx_q      <= '0;
            gap_q      <= '0;
            tcnt_q     <= '0;
            rd_vld_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            pix_vld_q  <= 1'b0;
            pix_last_q <= 1'b0;
            pix_q      <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            tout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            tcnt_q     <= tcnt_d;
            rd_vld_q   <= rd_vld_d;
            rd_last_q  <= rd_last_d;
            pix_vld_q  <= pix_vld_d;
            pix_last_q <= pix_last_d;
            pix_q      <= pix_d;
            result_q   <= result_d;
            done_q     <= done_d;
            tout_q     <= tout_d;
        end
    end

    assign busy_o        = busy_q;
    assign pixel_out_o   = pix_q;
    assign pixel_valid_o = pix_vld_q;
    assign result_o      = result_q;
    assign result_done_o = done_q;
    assign timeout_err_o = tout_q;

endmodule

// File: tb/tb_mnist_frame_feeder.sv
// Testbench for mnist_frame_feeder.
// Unit 0 runs with GAP=0 and unit 1 with GAP=2. Both units use TIMEOUT_CYCLES=50.
// The stimulus pushes the expected pixels and result events into scoreboard queues.
// A negedge monitor pops those entries and compares them with whatever each unit presents.
module tb_mnist_frame_feeder;

    localparam int NPIX = 784;
    localparam int TMO  = 50;

    typedef struct packed {
        logic       u;
        logic [9:0] idx;
        logic [7:0] v;
    } pix_t;

    typedef struct packed {
        logic        u;
        logic        tout;
        logic [31:0] val;
    } evt_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en [2];
    logic [9:0]  wr_addr [2];
    logic [7:0]  wr_data [2];
    logic        start [2];
    logic [31:0] core_result [2];
    logic        core_result_valid [2];
    logic [1:0]  busy;
    logic [7:0]  pixel_out [2];
    logic [1:0]  pixel_valid;
    logic [31:0] result [2];
    logic [1:0]  result_done;
    logic [1:0]  timeout_err;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        mnist_frame_feeder #(
            .N_PIXELS(NPIX), .ADDR_W(10), .GAP(gi * 2), .TIMEOUT_CYCLES(TMO)
        ) u_dut (
            .clk                (clk),
            .rst_n              (rst_n),
            .wr_en_i            (wr_en[gi]),
            .wr_addr_i          (wr_addr[gi]),
            .wr_data_i          (wr_data[gi]),
            .start_i            (start[gi]),
            .busy_o             (busy[gi]),
            .pixel_out_o        (pixel_out[gi]),
            .pixel_valid_o      (pixel_valid[gi]),
            .core_result_i      (core_result[gi]),
            .core_result_valid_i(core_result_valid[gi]),
            .result_o           (result[gi]),
            .result_done_o      (result_done[gi]),
            .timeout_err_o      (timeout_err[gi])
        );
    end

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   start_cyc [2];
    int   last_vcyc [2];
    int   pix_seen [2];
    logic first_pend [2];
    logic [7:0] model [2][NPIX];
    pix_t exp_pix [$];
    evt_t exp_evt [$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            for (int u = 0; u < 2; u++) begin
                if (pixel_valid[u]) begin
                    if (exp_pix.size() == 0) begin
                        chk($sformatf("unexpected_pixel_u%0d", u), {31'd0, pixel_valid[u]}, 32'd0);
                    end else begin
                        pix_t p;
                        p = exp_pix.pop_front();
                        chk($sformatf("pix_unit_u%0d", u), u, {31'd0, p.u});
                        chk($sformatf("pix[%0d]_u%0d", p.idx, u), {24'd0, pixel_out[u]}, {24'd0, p.v});
                        chk($sformatf("busy_in_stream_u%0d", u), {31'd0, busy[u]}, 32'd1);
                        if (first_pend[u]) begin
                            chk($sformatf("first_latency_u%0d", u), cyc - start_cyc[u], 32'd2);
                            first_pend[u] = 1'b0;
                        end else begin
                            chk($sformatf("spacing[%0d]_u%0d", p.idx, u), cyc - last_vcyc[u], (u == 0) ? 32'd1 : 32'd3);
                        end
                    end
                    last_vcyc[u] = cyc;
                    pix_seen[u]++;
                end
                if (result_done[u] || timeout_err[u]) begin
                    if (exp_evt.size() == 0) begin
                        chk($sformatf("unexpected_event_u%0d", u), {30'd0, result_done[u], timeout_err[u]}, 32'd0);
                    end else begin
                        evt_t e;
                        e = exp_evt.pop_front();
                        $display("event u%0d: done=%0b tout=%0b result=%08h", u, result_done[u], timeout_err[u], result[u]);
                        chk($sformatf("evt_unit_u%0d", u), u, {31'd0, e.u});
                        chk($sformatf("evt_timeout_u%0d", u), {31'd0, timeout_err[u]}, {31'd0, e.tout});
                        chk($sformatf("evt_done_u%0d", u), {31'd0, result_done[u]}, {31'd0, ~e.tout});
                        chk($sformatf("evt_result_u%0d", u), result[u], e.val);
                        chk($sformatf("evt_busy_low_u%0d", u), {31'd0, busy[u]}, 32'd0);
                        if (e.tout) begin
                            chk($sformatf("timeout_delay_u%0d", u), cyc - last_vcyc[u], TMO + 1);
                        end
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_start(input int u);
        tick;
        start[u] = 1'b1;
        start_cyc[u] = cyc + 1;
        first_pend[u] = 1'b1;
        for (int a = 0; a < NPIX; a++) begin
            exp_pix.push_back('{u: u[0], idx: a[9:0], v: model[u][a]});
        end
        tick;
        start[u] = 1'b0;
    endtask

    task automatic wait_pix(input int u, input int target, input int budget);
        int k = 0;
        while (pix_seen[u] < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk($sformatf("stream_progress_u%0d", u), pix_seen[u], target);
    endtask

    task automatic deliver(input int u, input logic [31:0] val, input logic with_start);
        tick;
        core_result[u] = val;
        core_result_valid[u] = 1'b1;
        start[u] = with_start;
        exp_evt.push_back('{u: u[0], tout: 1'b0, val: val});
        tick;
        core_result_valid[u] = 1'b0;
        start[u] = 1'b0;
    endtask

    task automatic wait_evt(input int budget);
        int k = 0;
        while (exp_evt.size() > 0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("event_drain", exp_evt.size(), 32'd0);
    endtask

    task automatic write_px(input int u, input int a, input logic [7:0] d);
        tick;
        wr_en[u] = 1'b1;
        wr_addr[u] = a[9:0];
        wr_data[u] = d;
        tick;
        wr_en[u] = 1'b0;
    endtask

    initial begin
        int base;
        for (int u = 0; u < 2; u++) begin
            wr_en[u] = 1'b0; wr_addr[u] = '0; wr_data[u] = '0; start[u] = 1'b0;
            core_result[u] = '0; core_result_valid[u] = 1'b0;
            start_cyc[u] = 0; last_vcyc[u] = 0; pix_seen[u] = 0; first_pend[u] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("rst_busy_u%0d", u), {31'd0, busy[u]}, 32'd0);
            chk($sformatf("rst_valid_u%0d", u), {31'd0, pixel_valid[u]}, 32'd0);
            chk($sformatf("rst_pixel_u%0d", u), {24'd0, pixel_out[u]}, 32'd0);
            chk($sformatf("rst_result_u%0d", u), result[u], 32'd0);
            chk($sformatf("rst_done_u%0d", u), {31'd0, result_done[u]}, 32'd0);
            chk($sformatf("rst_tout_u%0d", u), {31'd0, timeout_err[u]}, 32'd0);
        end
        rst_n = 1'b1;

        // Frame: pixel value = addr mod 256, written to both units.
        for (int a = 0; a < NPIX; a++) begin
            tick;
            for (int u = 0; u < 2; u++) begin
                wr_en[u] = 1'b1; wr_addr[u] = a[9:0]; wr_data[u] = a[7:0];
                model[u][a] = a[7:0];
            end
        end
        tick;
        wr_en[0] = 1'b0; wr_en[1] = 1'b0;

        // GAP=0 stream, then a result with start on the same cycle (start ignored).
        base = pix_seen[0];
        run_start(0);
        wait_pix(0, base + NPIX, NPIX + 20);
        deliver(0, 32'h0000_0007, 1'b1);
        wait_evt(20);
        @(negedge clk); #1;
        chk("busy_after_exit_start", {31'd0, busy[0]}, 32'd0);

        // Timeout: no result, the previous result (7) must survive.
        base = pix_seen[0];
        run_start(0);
        exp_evt.push_back('{u: 1'b0, tout: 1'b1, val: 32'h0000_0007});
        wait_pix(0, base + NPIX, NPIX + 20);
        wait_evt(TMO + 20);

        // Interference mid-stream: write, start and result are all ignored.
        base = pix_seen[0];
        run_start(0);
        wait_pix(0, base + 100, 200);
        tick;
        wr_en[0] = 1'b1; wr_addr[0] = 10'd5; wr_data[0] = 8'hAA;
        start[0] = 1'b1;
        core_result[0] = 32'hDEAD_BEEF; core_result_valid[0] = 1'b1;
        tick;
        wr_en[0] = 1'b0; start[0] = 1'b0; core_result_valid[0] = 1'b0;
        wait_pix(0, base + NPIX, NPIX + 20);
        deliver(0, 32'h1234_5678, 1'b0);
        wait_evt(20);

        // Idle writes: last address accepted, one past the end dropped.
        write_px(0, 783, 8'hC3);
        model[0][783] = 8'hC3;
        write_px(0, 784, 8'h77);

        base = pix_seen[0];
        run_start(0);
        wait_pix(0, base + NPIX, NPIX + 20);
        deliver(0, 32'hCAFE_F00D, 1'b0);
        wait_evt(20);

        // Reset at pixel 400, then a full replay from the intact buffer.
        base = pix_seen[0];
        run_start(0);
        wait_pix(0, base + 400, 600);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, pixel_valid[0]}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy[0]}, 32'd0);
        chk("rst_mid_result", result[0], 32'd0);
        exp_pix.delete();
        first_pend[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        base = pix_seen[0];
        run_start(0);
        wait_pix(0, base + NPIX, NPIX + 20);
        deliver(0, 32'h0000_0055, 1'b0);
        wait_evt(20);

        // GAP=2 unit: same frame, pixels three cycles apart.
        base = pix_seen[1];
        run_start(1);
        wait_pix(1, base + NPIX, 3 * NPIX + 20);
        deliver(1, 32'hA5A5_A5A5, 1'b0);
        wait_evt(20);

        repeat (5) tick;
        chk("pixels_left", exp_pix.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
